// File: rtl/router_pkt_src_if.sv
// router_pkt_src_if: host/FIFO, command, status and router-side signals of the packet source
interface router_pkt_src_if #(
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_W      = 16
);
  logic                          wr_en;
  logic [7:0]                    wr_data;
  logic                          fifo_full;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          start;
  logic [1:0]                    dest_addr;
  logic [5:0]                    pld_len;
  logic                          start_ack;
  logic                          cfg_err;
  logic                          busy;
  logic                          err;
  logic                          pkt_valid;
  logic [7:0]                    dout;
  logic                          tx_busy;
  logic                          done;
  logic                          pkt_err;
  logic [CNT_W-1:0]              pkt_cnt;
  modport master (
    output wr_en, wr_data, start, dest_addr, pld_len, busy, err,
    input  fifo_full, fifo_count, start_ack, cfg_err, pkt_valid, dout, tx_busy, done, pkt_err, pkt_cnt
  );
  modport slave (
    input  wr_en, wr_data, start, dest_addr, pld_len, busy, err,
    output fifo_full, fifo_count, start_ack, cfg_err, pkt_valid, dout, tx_busy, done, pkt_err, pkt_cnt
  );
endinterface

// File: rtl/router_pkt_src.sv
// router_pkt_src: buffers payload bytes and emits header/payload/parity packets to the router input port
module router_pkt_src #(
  parameter int FIFO_DEPTH = 64,
  parameter int GAP_CYCLES = 2,
  parameter int ERR_WIN    = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  router_pkt_src_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, HDR, PLD, PAR, ECHK, GAP} state_t;
  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic [7:0]       head, par, dout_r;
  logic [5:0]       rem;
  logic [7:0]       ecnt, gcnt;
  logic [CNT_W-1:0] pkt_cnt_r;
  logic             push, pop, take, bad, eacc;
  logic             pkt_valid_r, start_ack_r, cfg_err_r, done_r, pkt_err_r;
  assign head           = mem[rptr];
  assign bus.fifo_full  = count == (AW+1)'(FIFO_DEPTH);
  assign bus.fifo_count = count;
  assign bus.tx_busy    = state != IDLE;
  assign bus.dout       = dout_r;
  assign bus.pkt_valid  = pkt_valid_r;
  assign bus.start_ack  = start_ack_r;
  assign bus.cfg_err    = cfg_err_r;
  assign bus.done       = done_r;
  assign bus.pkt_err    = pkt_err_r;
  assign bus.pkt_cnt    = pkt_cnt_r;
  assign push = bus.wr_en && !bus.fifo_full;
  assign take = (state == HDR || state == PLD || state == PAR) && !bus.busy;
  assign pop  = take && state != PAR && rem != 6'd0;
  assign bad  = bus.dest_addr == 2'd3 || bus.pld_len == 6'd0;
  // payload storage, no reset needed since occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.wr_data;
  end
  // FIFO pointers and occupancy; a push while full is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // packet sequencer with registered router-side and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dout_r      <= '0;
      pkt_valid_r <= 1'b0;
      start_ack_r <= 1'b0;
      cfg_err_r   <= 1'b0;
      done_r      <= 1'b0;
      pkt_err_r   <= 1'b0;
      pkt_cnt_r   <= '0;
      par         <= '0;
      rem         <= '0;
      ecnt        <= '0;
      gcnt        <= '0;
      eacc        <= 1'b0;
    end else begin
      start_ack_r <= 1'b0;
      cfg_err_r   <= 1'b0;
      done_r      <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          if (bad) cfg_err_r <= 1'b1;
          else if (count >= (AW+1)'(bus.pld_len)) begin
            start_ack_r <= 1'b1;
            dout_r      <= {bus.pld_len, bus.dest_addr};
            par         <= {bus.pld_len, bus.dest_addr};
            pkt_valid_r <= 1'b1;
            rem         <= bus.pld_len;
            state       <= HDR;
          end
        end
        HDR, PLD: if (take) begin
          if (rem != 6'd0) begin
            dout_r <= head;
            par    <= par ^ head;
            rem    <= rem - 6'd1;
            state  <= PLD;
          end else begin
            dout_r      <= par;
            pkt_valid_r <= 1'b0;
            state       <= PAR;
          end
        end
        PAR: if (take) begin
          dout_r <= '0;
          eacc   <= 1'b0;
          ecnt   <= '0;
          state  <= ECHK;
        end
        ECHK: begin
          eacc <= eacc | bus.err;
          ecnt <= ecnt + 8'd1;
          if (ecnt == 8'(ERR_WIN - 1)) begin
            done_r    <= 1'b1;
            pkt_err_r <= eacc | bus.err;
            pkt_cnt_r <= pkt_cnt_r + CNT_W'(1);
            gcnt      <= '0;
            state     <= GAP;
          end
        end
        GAP: begin
          gcnt <= gcnt + 8'd1;
          if (gcnt == 8'(GAP_CYCLES - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
